sync_fwft_fifo_lvl: RTL

//  Parametrised single-clock first-word-fall-through FIFO for UART TX/RX buffering.

---
 rtl/sync_fwft_fifo_lvl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/sync_fwft_fifo_lvl.sv
// rtl/sync_fwft_fifo_lvl.sv - single-clock FWFT FIFO with level flags, flush and sticky errors
//
// Purpose: byte/word buffer between the UART byte engines and the host/bus side.
//   The head word is presented on fifo_data_o (registered) whenever fifo_empty_o is low;
//   fifo_rd_en_i pops it. Depth is 2**ADDR_WIDTH.
// Ports:
//   clk_i               clock, rising edge
//   rst_n_i             asynchronous active-low reset
//   fifo_flush_i        synchronous flush, highest priority
//   fifo_wr_en_i        write request
//   fifo_data_i         write data
//   fifo_full_o         no free entries
//   fifo_almost_full_o  count >= AF_THRESH
//   fifo_rd_en_i        pop request
//   fifo_data_o         head word, valid while !fifo_empty_o
//   fifo_empty_o        no valid head word
//   fifo_almost_empty_o count <= AE_THRESH
//   fifo_count_o        stored words, 0..DEPTH
//   fifo_overflow_o     sticky: write attempted while full
//   fifo_underflow_o    sticky: read attempted while empty
module sync_fwft_fifo_lvl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_THRESH  = 12,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  fifo_flush_i,
  input  logic                  fifo_wr_en_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic                  fifo_full_o,
  output logic                  fifo_almost_full_o,
  input  logic                  fifo_rd_en_i,
  output logic [DATA_WIDTH-1:0] fifo_data_o,
  output logic                  fifo_empty_o,
  output logic                  fifo_almost_empty_o,
  output logic [ADDR_WIDTH:0]   fifo_count_o,
  output logic                  fifo_overflow_o,
  output logic                  fifo_underflow_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] AF_LVL = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_LVL = (ADDR_WIDTH+1)'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   rd_ptr_inc;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic [ADDR_WIDTH:0]   count;
  logic                  empty;
  logic                  full;
  logic                  wr_acc;
  logic                  rd_acc;

  // Status is decoded purely from registered pointers, so no input reaches an output.
  assign count = wr_ptr_q - rd_ptr_q;
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                 (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);

  assign wr_acc     = fifo_wr_en_i & ~full  & ~fifo_flush_i;
  assign rd_acc     = fifo_rd_en_i & ~empty & ~fifo_flush_i;
  assign rd_ptr_inc = rd_ptr_q + 1'b1;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    data_d      = data_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (fifo_flush_i) begin
      // data_o deliberately holds its last value across a flush.
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_d = rd_ptr_inc;
      if (fifo_wr_en_i && full)  overflow_d  = 1'b1;
      if (fifo_rd_en_i && empty) underflow_d = 1'b1;

      // Keep the registered head equal to storage[rd_ptr]. When the next head is the
      // entry being written this same cycle (count 1 with write+pop, or write into
      // empty), storage is not yet updated, so bypass the write data.
      if (rd_acc) begin
        if (rd_ptr_inc != wr_ptr_q) begin
          data_d = mem_q[rd_ptr_inc[ADDR_WIDTH-1:0]];
        end else if (wr_acc) begin
          data_d = fifo_data_i;
        end
      end else if (empty && wr_acc) begin
        data_d = fifo_data_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      data_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      data_q      <= data_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not reset.
  always_ff @(posedge clk_i) begin
    if (wr_acc) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= fifo_data_i;
  end

  assign fifo_full_o         = full;
  assign fifo_empty_o        = empty;
  assign fifo_count_o        = count;
  assign fifo_almost_full_o  = (count >= AF_LVL);
  assign fifo_almost_empty_o = (count <= AE_LVL);
  assign fifo_data_o         = data_q;
  assign fifo_overflow_o     = overflow_q;
  assign fifo_underflow_o    = underflow_q;

endmodule
